// File: rtl/seq_stream_ctrl.sv
// ============================================================================
// Module   : seq_stream_ctrl
// Purpose  : Sequencer and input arbiter feeding the shared 1011 serial
//            detector from either a manual bit stream or a programmed
//            pattern played back at a fixed interval, with hit counting.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_stream_ctrl #(
    parameter int INTERVAL = 4,
    parameter int MAXLEN   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_we_i,
    input  logic [MAXLEN-1:0] cfg_pattern_i,
    input  logic [4:0]        cfg_len_i,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic              man_valid_i,
    input  logic              man_bit_i,
    input  logic              det_hit_i,
    output logic              bit_out_o,
    output logic              bit_valid_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [7:0]        hit_count_o,
    output logic              man_drop_o,
    output logic [1:0]        state_dbg_o
);

    localparam int          IDXW     = $clog2(MAXLEN);
    localparam logic [4:0]  LEN_MAX  = 5'(MAXLEN);
    localparam logic [9:0]  CNT_LOAD = 10'(INTERVAL - 1);

    localparam logic [1:0]  ST_IDLE  = 2'd0;
    localparam logic [1:0]  ST_ISSUE = 2'd1;
    localparam logic [1:0]  ST_GAP   = 2'd2;
    localparam logic [1:0]  ST_DONE  = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [MAXLEN-1:0] pattern_q, pattern_d;
    logic [4:0]        len_q, len_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic [9:0]        cnt_q, cnt_d;
    logic              bit_out_q, bit_out_d;
    logic              bit_valid_q, bit_valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [7:0]        hit_q, hit_d;
    logic              man_drop_q, man_drop_d;
    logic              w_busy;

    assign w_busy = (state_q == ST_ISSUE) || (state_q == ST_GAP);

    always_comb begin
        state_d     = state_q;
        pattern_d   = pattern_q;
        len_d       = len_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        bit_out_d   = bit_out_q;
        bit_valid_d = 1'b0;
        man_drop_d  = 1'b0;
        hit_d       = hit_q;

        if (w_busy && det_hit_i && (hit_q != 8'hFF)) begin
            hit_d = hit_q + 8'd1;
        end

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (state_q == ST_DONE) begin
                    state_d = ST_IDLE;
                end
                if (cfg_we_i) begin
                    pattern_d = cfg_pattern_i;
                    len_d     = (cfg_len_i > LEN_MAX) ? LEN_MAX : cfg_len_i;
                end
                // start takes priority over a coincident manual bit
                if ((state_q == ST_IDLE) && start_i) begin
                    hit_d      = 8'd0;
                    man_drop_d = man_valid_i;
                    if (len_q == 5'd0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d     = ST_ISSUE;
                        idx_d       = IDXW'(len_q - 5'd1);
                        bit_valid_d = 1'b1;
                        bit_out_d   = pattern_q[IDXW'(len_q - 5'd1)];
                    end
                end else if (man_valid_i) begin
                    bit_valid_d = 1'b1;
                    bit_out_d   = man_bit_i;
                end
            end
            ST_ISSUE: begin
                state_d    = ST_GAP;
                cnt_d      = CNT_LOAD;
                man_drop_d = man_valid_i;
            end
            default: begin
                cnt_d      = cnt_q - 10'd1;
                man_drop_d = man_valid_i;
                if (cnt_q == 10'd1) begin
                    if (idx_q == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d     = ST_ISSUE;
                        idx_d       = idx_q - IDXW'(1);
                        bit_valid_d = 1'b1;
                        bit_out_d   = pattern_q[idx_q - IDXW'(1)];
                    end
                end
            end
        endcase

        if (w_busy && abort_i) begin
            state_d     = ST_IDLE;
            bit_valid_d = 1'b0;
            bit_out_d   = bit_out_q;
        end

        busy_d = (state_d == ST_ISSUE) || (state_d == ST_GAP);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            pattern_q   <= '0;
            len_q       <= '0;
            idx_q       <= '0;
            cnt_q       <= '0;
            bit_out_q   <= 1'b0;
            bit_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            hit_q       <= '0;
            man_drop_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pattern_q   <= pattern_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            bit_out_q   <= bit_out_d;
            bit_valid_q <= bit_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            hit_q       <= hit_d;
            man_drop_q  <= man_drop_d;
        end
    end

    assign bit_out_o   = bit_out_q;
    assign bit_valid_o = bit_valid_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign hit_count_o = hit_q;
    assign man_drop_o  = man_drop_q;
    assign state_dbg_o = state_q;

endmodule

`default_nettype wire

// File: doc/seq_stream_ctrl.md
Name: seq_stream_ctrl

Overview:
- Sequencer and input arbiter in front of the shared 1011 serial sequence detector.
- Drives the detector's single bit/valid input from one of two sources:
  - a manual bit stream (from the button edge detectors);
  - an automatic playback of a programmed pattern of up to 16 bits.
- During playback it counts detector hits and reports completion. This gives on-board self-test and demo sequencing without button presses.

Parameters:
- INTERVAL, 4, cycles between consecutive auto-issued bit_valid pulses; legal range 2..1023.
- MAXLEN, 16, pattern register width in bits; cfg_len is clamped to this value.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- cfg_we  in  1  config write strobe; ignored while busy
- cfg_pattern  in  16  pattern bits; issued MSB-first from bit index len-1 down to bit 0
- cfg_len  in  5  pattern length 0..31; values >16 clamp to 16
- start  in  1  one-cycle pulse that begins playback; ignored while busy
- abort  in  1  one-cycle pulse that terminates playback immediately
- man_valid  in  1  manual bit strobe (one-cycle pulse)
- man_bit  in  1  manual bit value
- det_hit  in  1  detection pulse returned from the detector
- bit_out  out  1  bit value presented to the detector
- bit_valid  out  1  one-cycle strobe qualifying bit_out
- busy  out  1  high during playback (ISSUE/GAP states)
- done  out  1  one-cycle pulse when playback completes normally
- hit_count  out  8  det_hit pulses seen during the last or current playback; saturates at 255
- man_drop  out  1  one-cycle pulse when a man_valid was discarded
- state_dbg  out  2  encoded state for HEX display: IDLE=0, ISSUE=1, GAP=2, DONE=3

Behaviour:
- Reset values: bit_out=0, bit_valid=0, busy=0, done=0, hit_count=0, man_drop=0, state=IDLE, pattern reg=0, length reg=0, interval counter=0.
- All outputs are registered.
- Config: cfg_we in IDLE or DONE latches cfg_pattern and min(cfg_len,16) at the clock edge. cfg_we while busy has no effect.
- IDLE, manual pass-through:
  - man_valid at cycle T gives bit_valid=1 and bit_out=man_bit at T+1 (1-cycle latency).
  - bit_out holds its last value when bit_valid=0.
- IDLE, start at cycle T:
  - hit_count clears to 0.
  - If the latched length is 0: go to DONE; done=1 at T+1; no bit_valid is issued.
  - Otherwise go to ISSUE.
- ISSUE (one cycle per bit):
  - bit_valid=1 and bit_out=pattern[idx], where idx starts at len-1.
  - Next state is GAP; interval counter loads INTERVAL-1.
- GAP:
  - Counter decrements each cycle.
  - At 1: if idx=0, go to DONE; else decrement idx and go to ISSUE.
- Playback timing for start at cycle T with length L:
  - First bit_valid at T+1.
  - Bit k (0-based) at T+1+k*INTERVAL.
  - done at T+1+L*INTERVAL.
  - The final GAP gives the detector INTERVAL-1 cycles to return its hit for the last bit.
- DONE: done=1 for exactly one cycle; return to IDLE next cycle.
- busy=1 exactly in the ISSUE and GAP states.
- Hit counting:
  - Every cycle with det_hit=1 while busy increments hit_count, saturating at 255.
  - det_hit outside busy is ignored, and hit_count holds.
- Arbitration:
  - man_valid while busy, or coincident with start in IDLE: the manual bit is discarded, man_drop=1 next cycle, and no bit_valid is generated for it. start wins.
  - man_valid in DONE: forwarded as in IDLE.
- abort:
  - In ISSUE or GAP: return to IDLE next cycle; bit_valid=0; no done pulse; hit_count retains its value.
  - In IDLE or DONE: no effect (a pending DONE still produces its done pulse).
  - abort and start in the same IDLE cycle: start is taken.
- Asynchronous reset mid-playback: immediate return to reset values; the pattern register is cleared.

Test Plan:
- Reset with INTERVAL=4, then man_valid pulses carrying bits 1,0,1,1 at cycles 10,20,30,40 → bit_valid at 11,21,31,41 with matching bit_out; busy stays 0; man_drop stays 0.
- cfg_pattern=16'h000B, cfg_len=4, start at cycle T, with the detector model returning det_hit one cycle after the 4th bit → bit_valid at T+1,T+5,T+9,T+13 with bits 1,0,1,1; hit_count=1; done at T+17; busy high T+1..T+16.
- cfg_pattern=16'hBBBB, cfg_len=20 (clamped to 16), overlapping-detector model → 16 bit_valids; done at T+65; hit_count=4.
- cfg_len=0, start → done at T+1; no bit_valid; hit_count=0.
- Playback with pattern 16'h000B, length 4; man_valid at T+3; abort at T+6 → man_drop=1 at T+4; state IDLE at T+7; no done pulse; no further bit_valid; hit_count unchanged.
- Force det_hit high for 300 cycles during a long playback → hit_count saturates at 255; start then clears it to 0. cfg_we during busy leaves the pattern unchanged; the next playback uses the old pattern.
